// File: rtl/axi4lite_arbiter_if.sv
// AXI4-Lite bus interface shared by the arbiter's upstream and downstream ports.
// The master modport drives requests; the slave modport receives them.
interface axi4lite #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                aclk;
  logic                aresetn;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4lite_arbiter.sv
// Two-port AXI4-Lite arbiter: instruction fetch (in0) and load/store (in1)
// share one downstream bus. Read and write channels arbitrate independently,
// one outstanding transaction per channel.
// Optional feature: define AXI_ARB_ROUND_ROBIN_EN for round-robin tie-break;
// otherwise port 1 wins every tie and no last-grant state exists.
module axi4lite_arbiter (
  input  logic     clk,
  input  logic     aresetn,
  axi4lite.slave   in0,
  axi4lite.slave   in1,
  axi4lite.master  out_bus
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;

  r_state_t r_state;
  w_state_t w_state;
  logic     r_gnt;
  logic     w_gnt;
  logic     aw_done;
  logic     w_done;
  logic     r_pick;
  logic     w_pick;
  logic     ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic     r_addr_ph, r_data_ph, w_addr_ph, w_resp_ph;
  logic     unused_in;

  assign out_bus.aclk    = clk;
  assign out_bus.aresetn = aresetn;

  // Upstream clock/reset copies are not needed inside the arbiter.
  assign unused_in = &{1'b0, in0.aclk, in0.aresetn, in1.aclk, in1.aresetn};

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic r_last;
  logic w_last;
  // Tie goes to the port not granted last time on the channel.
  always_comb begin
    r_pick = in1.arvalid & (~in0.arvalid | ~r_last);
    w_pick = in1.awvalid & (~in0.awvalid | ~w_last);
  end
`else
  // Load/store port always wins ties.
  always_comb begin
    r_pick = in1.arvalid;
    w_pick = in1.awvalid;
  end
`endif

  assign r_addr_ph = (r_state == R_ADDR);
  assign r_data_ph = (r_state == R_DATA);
  assign w_addr_ph = (w_state == W_ADDR);
  assign w_resp_ph = (w_state == W_RESP);

  assign ar_hs = out_bus.arvalid & out_bus.arready;
  assign r_hs  = out_bus.rvalid  & out_bus.rready;
  assign aw_hs = out_bus.awvalid & out_bus.awready;
  assign w_hs  = out_bus.wvalid  & out_bus.wready;
  assign b_hs  = out_bus.bvalid  & out_bus.bready;

  // Read channel FSM: grant in idle, then address and data phases.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      r_last  <= 1'b1;
`endif
    end else begin
      case (r_state)
        R_IDLE: if (in0.arvalid | in1.arvalid) begin
          r_gnt   <= r_pick;
          r_state <= R_ADDR;
        end
        R_ADDR: if (ar_hs) r_state <= R_DATA;
        R_DATA: if (r_hs) begin
          r_state <= R_IDLE;
`ifdef AXI_ARB_ROUND_ROBIN_EN
          r_last  <= r_gnt;
`endif
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel FSM: AW and W may complete in either order; flags track them.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      w_last  <= 1'b1;
`endif
    end else begin
      case (w_state)
        W_IDLE: if (in0.awvalid | in1.awvalid) begin
          w_gnt   <= w_pick;
          w_state <= W_ADDR;
        end
        W_ADDR: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            w_state <= W_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        W_RESP: if (b_hs) begin
          w_state <= W_IDLE;
`ifdef AXI_ARB_ROUND_ROBIN_EN
          w_last  <= w_gnt;
`endif
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Downstream request mux from the registered grants.
  assign out_bus.araddr  = r_gnt ? in1.araddr : in0.araddr;
  assign out_bus.arprot  = r_gnt ? in1.arprot : in0.arprot;
  assign out_bus.arvalid = r_addr_ph & (r_gnt ? in1.arvalid : in0.arvalid);
  assign out_bus.rready  = r_data_ph & (r_gnt ? in1.rready  : in0.rready);

  assign out_bus.awaddr  = w_gnt ? in1.awaddr : in0.awaddr;
  assign out_bus.awprot  = w_gnt ? in1.awprot : in0.awprot;
  assign out_bus.awvalid = w_addr_ph & ~aw_done & (w_gnt ? in1.awvalid : in0.awvalid);
  assign out_bus.wdata   = w_gnt ? in1.wdata : in0.wdata;
  assign out_bus.wstrb   = w_gnt ? in1.wstrb : in0.wstrb;
  assign out_bus.wvalid  = w_addr_ph & ~w_done & (w_gnt ? in1.wvalid : in0.wvalid);
  assign out_bus.bready  = w_resp_ph & (w_gnt ? in1.bready : in0.bready);

  // Upstream responses: only the granted port ever sees ready/valid.
  assign in0.arready = r_addr_ph & ~r_gnt & out_bus.arready;
  assign in1.arready = r_addr_ph &  r_gnt & out_bus.arready;
  assign in0.rvalid  = r_data_ph & ~r_gnt & out_bus.rvalid;
  assign in1.rvalid  = r_data_ph &  r_gnt & out_bus.rvalid;
  assign in0.rdata   = out_bus.rdata;
  assign in1.rdata   = out_bus.rdata;
  assign in0.rresp   = out_bus.rresp;
  assign in1.rresp   = out_bus.rresp;

  assign in0.awready = w_addr_ph & ~w_gnt & ~aw_done & out_bus.awready;
  assign in1.awready = w_addr_ph &  w_gnt & ~aw_done & out_bus.awready;
  assign in0.wready  = w_addr_ph & ~w_gnt & ~w_done & out_bus.wready;
  assign in1.wready  = w_addr_ph &  w_gnt & ~w_done & out_bus.wready;
  assign in0.bvalid  = w_resp_ph & ~w_gnt & out_bus.bvalid;
  assign in1.bvalid  = w_resp_ph &  w_gnt & out_bus.bvalid;
  assign in0.bresp   = out_bus.bresp;
  assign in1.bresp   = out_bus.bresp;

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Directed bench for axi4lite_arbiter: table of read arbitration vectors plus
// hand-written write, concurrency and reset sequences.
module tb_axi4lite_arbiter;

  localparam logic [31:0] A0 = 32'h0000_1100;
  localparam logic [31:0] A1 = 32'h0000_2200;
  localparam logic [31:0] DA = 32'h0000_000A;
  localparam logic [31:0] DB = 32'h0000_000B;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   aw_cnt = 0;
  int   w_cnt = 0;

  axi4lite u0();
  axi4lite u1();
  axi4lite ub();

  assign u0.aclk    = clk;
  assign u0.aresetn = aresetn;
  assign u1.aclk    = clk;
  assign u1.aresetn = aresetn;

  axi4lite_arbiter dut (
    .clk     (clk),
    .aresetn (aresetn),
    .in0     (u0),
    .in1     (u1),
    .out_bus (ub)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ub.awvalid && ub.awready) aw_cnt <= aw_cnt + 1;
    if (ub.wvalid  && ub.wready)  w_cnt  <= w_cnt + 1;
  end

  typedef struct {
    logic r0;
    logic r1;
    logic g;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    u0.arvalid = 0; u0.araddr = A0; u0.arprot = 3'd0; u0.rready = 1;
    u0.awvalid = 0; u0.awaddr = '0; u0.awprot = 3'd0; u0.wvalid = 0;
    u0.wdata = '0; u0.wstrb = '1; u0.bready = 1;
    u1.arvalid = 0; u1.araddr = A1; u1.arprot = 3'd0; u1.rready = 1;
    u1.awvalid = 0; u1.awaddr = '0; u1.awprot = 3'd0; u1.wvalid = 0;
    u1.wdata = '0; u1.wstrb = '1; u1.bready = 1;
    ub.arready = 0; ub.rvalid = 0; ub.rdata = '0; ub.rresp = 2'd0;
    ub.awready = 0; ub.wready = 0; ub.bvalid = 0; ub.bresp = 2'd0;
  endtask

  // One read transaction with the slave answering by address: A0->0xA, A1->0xB.
  task automatic rd_txn(input logic r0, input logic r1, input logic g, input string tag);
    logic [31:0] cap;
    u0.arvalid = r0; u0.araddr = A0; u0.rready = (g == 1'b0);
    u1.arvalid = r1; u1.araddr = A1; u1.rready = (g == 1'b1);
    tick();
    chk({tag, "_arvalid"}, {31'd0, ub.arvalid}, 32'd1);
    chk({tag, "_araddr"}, ub.araddr, g ? A1 : A0);
    cap = ub.araddr;
    ub.arready = 1;
    #1;
    chk({tag, "_arready"}, {30'd0, u1.arready, u0.arready}, g ? 32'd2 : 32'd1);
    tick();
    ub.arready = 0;
    u0.arvalid = 0;
    u1.arvalid = 0;
    ub.rvalid = 1;
    ub.rdata = (cap == A1) ? DB : DA;
    #1;
    chk({tag, "_rvalid"}, {30'd0, u1.rvalid, u0.rvalid}, g ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, g ? u1.rdata : u0.rdata, g ? DB : DA);
    chk({tag, "_rready"}, {31'd0, ub.rready}, 32'd1);
    tick();
    ub.rvalid = 0;
    #1;
    chk({tag, "_idle"}, {30'd0, ub.arvalid, ub.rready}, 32'd0);
    u0.rready = 1;
    u1.rready = 1;
  endtask

  initial begin
    vec_t tbl[6];
    int   aw0, w0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    tbl[0] = '{1, 1, 0};
    tbl[1] = '{1, 1, 1};
    tbl[2] = '{1, 0, 0};
    tbl[3] = '{0, 1, 1};
    tbl[4] = '{1, 1, 0};
    tbl[5] = '{1, 1, 1};
`else
    tbl[0] = '{1, 1, 1};
    tbl[1] = '{1, 1, 1};
    tbl[2] = '{1, 0, 0};
    tbl[3] = '{0, 1, 1};
    tbl[4] = '{1, 1, 1};
    tbl[5] = '{1, 1, 1};
`endif

    // Reset with both ports requesting reads.
    idle_inputs();
    u0.arvalid = 1;
    u1.arvalid = 1;
    aresetn = 0;
    tick();
    tick();
    chk("rst_out_valids", {27'd0, ub.arvalid, ub.awvalid, ub.wvalid, ub.rready, ub.bready}, 32'd0);
    chk("rst_in_readies", {22'd0, u0.arready, u1.arready, u0.awready, u1.awready,
                           u0.wready, u1.wready, u0.rvalid, u1.rvalid, u0.bvalid, u1.bvalid}, 32'd0);
    aresetn = 1;
    tick();
    chk("rst_first_arvalid", {31'd0, ub.arvalid}, 32'd1);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    chk("rst_first_araddr", ub.araddr, A0);
`else
    chk("rst_first_araddr", ub.araddr, A1);
`endif
    aresetn = 0;
    idle_inputs();
    tick();
    aresetn = 1;
    tick();

    // Read arbitration table.
    foreach (tbl[i]) begin
      rd_txn(tbl[i].r0, tbl[i].r1, tbl[i].g, $sformatf("rd%0d", i));
    end

    // Write from port 0: wready arrives 3 cycles ahead of awready.
    aw0 = aw_cnt;
    w0  = w_cnt;
    u0.awvalid = 1; u0.awaddr = 32'h30; u0.wvalid = 1; u0.wdata = 32'h55;
    tick();
    chk("wr_awvalid", {31'd0, ub.awvalid}, 32'd1);
    chk("wr_wvalid", {31'd0, ub.wvalid}, 32'd1);
    chk("wr_awaddr", ub.awaddr, 32'h30);
    ub.wready = 1;
    #1;
    chk("wr_wready_route", {30'd0, u1.wready, u0.wready}, 32'd1);
    tick();
    chk("wr_wvalid_gated", {31'd0, ub.wvalid}, 32'd0);
    chk("wr_wready_gated", {31'd0, u0.wready}, 32'd0);
    chk("wr_awvalid_held", {31'd0, ub.awvalid}, 32'd1);
    tick();
    tick();
    ub.awready = 1;
    #1;
    chk("wr_awready_route", {30'd0, u1.awready, u0.awready}, 32'd1);
    tick();
    ub.awready = 0; ub.wready = 0;
    u0.awvalid = 0; u0.wvalid = 0;
    chk("wr_aw_hs_count", aw_cnt - aw0, 32'd1);
    chk("wr_w_hs_count", w_cnt - w0, 32'd1);
    ub.bvalid = 1; ub.bresp = 2'd0;
    u0.bready = 1; u1.bready = 0;
    #1;
    chk("wr_bvalid_route", {30'd0, u0.bvalid, u1.bvalid}, 32'd2);
    chk("wr_bresp", {30'd0, u0.bresp}, 32'd0);
    chk("wr_bready", {31'd0, ub.bready}, 32'd1);
    tick();
    ub.bvalid = 0;
    u1.bready = 1;
    #1;
    chk("wr_idle", {30'd0, u0.bvalid, ub.awvalid}, 32'd0);

    // Concurrent port-1 write and port-0 read.
    u1.awvalid = 1; u1.awaddr = 32'h1000; u1.wvalid = 1; u1.wdata = 32'hBEEF;
    u0.arvalid = 1; u0.araddr = 32'h2000;
    tick();
    chk("cc_both_valid", {30'd0, ub.awvalid, ub.arvalid}, 32'd3);
    chk("cc_awaddr", ub.awaddr, 32'h1000);
    chk("cc_araddr", ub.araddr, 32'h2000);
    chk("cc_wdata", ub.wdata, 32'hBEEF);
    ub.arready = 1; ub.awready = 1; ub.wready = 1;
    tick();
    ub.arready = 0; ub.awready = 0; ub.wready = 0;
    u1.awvalid = 0; u1.wvalid = 0; u0.arvalid = 0;
    ub.rvalid = 1; ub.rdata = DA; ub.bvalid = 1;
    #1;
    chk("cc_rvalid_route", {30'd0, u1.rvalid, u0.rvalid}, 32'd1);
    chk("cc_bvalid_route", {30'd0, u1.bvalid, u0.bvalid}, 32'd2);
    tick();
    ub.rvalid = 0; ub.bvalid = 0;
    #1;
    chk("cc_idle", {28'd0, ub.arvalid, ub.awvalid, ub.rready, ub.bready}, 32'd0);

    // Reset in the middle of a read data phase.
    u0.arvalid = 1; u0.araddr = A0;
    tick();
    ub.arready = 1;
    tick();
    ub.arready = 0; u0.arvalid = 0;
    ub.rvalid = 1; ub.rdata = DA;
    #1;
    chk("mr_rvalid_before", {31'd0, u0.rvalid}, 32'd1);
    aresetn = 0;
    #1;
    chk("mr_after_reset", {29'd0, ub.rready, u0.rvalid, u1.rvalid}, 32'd0);
    ub.rvalid = 0;
    tick();
    aresetn = 1;
    tick();
    rd_txn(1'b1, 1'b0, 1'b0, "mr_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
